serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, instruction-ROM address width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load_i  input  1  level; high = loading session active.
REQ-005 SHALL have port bit_i  input  1  serial program bit, MSB of each word first.
REQ-006 SHALL have port bit_valid_i  input  1  bit_i qualifier; at most one bit per cycle.
REQ-007 SHALL have port rom_we_o  output  1  one-cycle ROM write strobe.
REQ-008 SHALL have port rom_addr_o  output  ADDR_W  ROM write address.
REQ-009 SHALL have port rom_data_o  output  16  ROM write data (assembled word).
REQ-010 SHALL have port cpu_hold_o  output  1  high = CPU held in reset.
REQ-011 SHALL have port done_o  output  1  high = load finished.
REQ-012 SHALL have port err_o  output  1  sticky: partial last word or address overflow.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-014 IDLE/DONE with load_i=1 SHALL go to LOAD and clear bit count, address, err_o and done_o.
REQ-015 SHALL accept a bit only in LOAD or WRITE with bit_valid_i=1; bits in other states SHALL be ignored (shift enable gated).
REQ-016 SHALL keep a 4-bit bit counter, incremented on each accepted bit, wrapping 15->0.
REQ-017 The accepted bit that wraps the counter 15->0 SHALL move the FSM to WRITE the following cycle.
REQ-018 In WRITE: rom_we_o=1 for exactly one cycle, rom_data_o = the 16 bits just received (first bit in bit 15), rom_addr_o = current address; address increments after the write.
REQ-019 A bit accepted during WRITE SHALL count as bit 0 of the next word; back-to-back bits every cycle SHALL lose no data.
REQ-020 From WRITE: load_i=1 -> LOAD; load_i=0 -> DONE.
REQ-021 In LOAD, load_i=0 -> DONE; if bit count != 0, err_o SHALL set and partial bits SHALL be discarded (no write).
REQ-022 Address counter SHALL be ADDR_W+1 bits; a word completing with count = 2**ADDR_W SHALL suppress rom_we_o, set err_o, and leave the address unchanged (no wrap).
REQ-023 cpu_hold_o SHALL be 1 in IDLE, LOAD, WRITE and 0 only in DONE; done_o SHALL be 1 only in DONE.
REQ-024 Latency: 16th bit accepted in cycle N -> rom_we_o high in cycle N+1.
REQ-025 rom_data_o SHALL equal the shift-register contents continuously; it is meaningful only when rom_we_o=1.

Reset
REQ-026 resetb low SHALL immediately force IDLE, rom_we_o=0, rom_addr_o=0, rom_data_o=0, cpu_hold_o=1, done_o=0, err_o=0, bit count 0.
REQ-027 Reset mid-load SHALL abandon the session; a new load requires load_i high after reset release.

Structure
REQ-028 SHALL instantiate the existing shift_register as the single sub-module (in_i=bit_i, en_i=gated bit_valid_i, out_o=rom_data_o).
REQ-029 FSM state enum and word width constant 16 SHALL live in shared package hack_pkg.
REQ-030 Bit counter, address counter, FSM SHALL be local to serial_loader; target 120-250 RTL lines.

Verification
REQ-031 Load 3 words 0x1234, 0xABCD, 0xFFFF, one bit per cycle, then drop load_i -> writes at addr 0,1,2 with those data; done_o=1, cpu_hold_o=0, err_o=0.
REQ-032 Same words with bit_valid_i pulsed every 3rd cycle -> identical writes; rom_we_o high exactly one cycle each, cycle after 16th bit.
REQ-033 Drop load_i after 0x00FF plus 5 bits -> one write (addr 0, data 0x00FF); DONE with err_o=1.
REQ-034 ADDR_W=2, send 5 words -> 4 writes addr 0..3, 5th suppressed, err_o=1, rom_addr_o stays 3-of-4 counter saturated.
REQ-035 Assert resetb low after 9 bits of word 2 -> all outputs at reset values same cycle; reload of 0x5A5A after release writes addr 0.
REQ-036 Toggle bit_valid_i in IDLE and DONE -> no writes, rom_data_o unchanged.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the serial program loader: FSM states and instruction word width.
package hack_pkg;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/shift_register.sv
// MSB-first serial-in/parallel-out shift register; the first bit shifted in ends up in the top bit.
module shift_register
  import hack_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         in_i,
  input  logic         en_i,
  output logic [W-1:0] out_o
);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      out_o <= '0;
    end else if (en_i) begin
      out_o <= {out_o[W-2:0], in_i};
    end
  end

endmodule

// File: rtl/serial_loader.sv
// Assembles a serial bit stream into 16-bit words and writes them to consecutive instruction-ROM
// addresses while holding the CPU in reset; releases the CPU when the loading session ends.
module serial_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              load_i,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [WORD_W-1:0] rom_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ADDR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic [3:0]      bit_cnt;
  logic [ADDR_W:0] addr_cnt;
  logic            shift_en;
  logic            word_done;

  // Bits are only taken while a session is active; WRITE keeps accepting so streaming never stalls.
  assign shift_en  = bit_valid_i && ((state == LOAD) || (state == WRITE));
  assign word_done = shift_en && (bit_cnt == 4'd15);

  shift_register #(.W(WORD_W)) u_shift (
    .clk    (clk),
    .resetb (resetb),
    .in_i   (bit_i),
    .en_i   (shift_en),
    .out_o  (rom_data_o)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      addr_cnt   <= '0;
      rom_we_o   <= 1'b0;
      rom_addr_o <= '0;
      cpu_hold_o <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rom_we_o <= 1'b0;
      if (shift_en) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      case (state)
        IDLE, DONE: begin
          if (load_i) begin
            state      <= LOAD;
            bit_cnt    <= 4'd0;
            addr_cnt   <= '0;
            rom_addr_o <= '0;
            err_o      <= 1'b0;
            done_o     <= 1'b0;
            cpu_hold_o <= 1'b1;
          end
        end

        LOAD: begin
          if (!load_i) begin
            // A partially received word is dropped and flagged.
            state      <= DONE;
            done_o     <= 1'b1;
            cpu_hold_o <= 1'b0;
            bit_cnt    <= 4'd0;
            if (bit_cnt != 4'd0) begin
              err_o <= 1'b1;
            end
          end else if (word_done) begin
            state <= WRITE;
            if (addr_cnt == ADDR_LIMIT) begin
              err_o <= 1'b1;
            end else begin
              rom_we_o   <= 1'b1;
              rom_addr_o <= addr_cnt[ADDR_W-1:0];
            end
          end
        end

        WRITE: begin
          if (rom_we_o) begin
            addr_cnt <= addr_cnt + ADDR_ONE;
          end
          if (load_i) begin
            state <= LOAD;
          end else begin
            state      <= DONE;
            done_o     <= 1'b1;
            cpu_hold_o <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Scoreboard bench for serial_loader: stimulus queues expected ROM writes, a negedge monitor checks them.
module tb_serial_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          load_i = 1'b0;
  logic          bit_i = 1'b0;
  logic          bit_valid_i = 1'b0;
  logic          rom_we_o;
  logic [AW-1:0] rom_addr_o;
  logic [15:0]   rom_data_o;
  logic          cpu_hold_o;
  logic          done_o;
  logic          err_o;

  serial_loader #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .load_i      (load_i),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .rom_we_o    (rom_we_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_o  (rom_data_o),
    .cpu_hold_o  (cpu_hold_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [15:0]   saved_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (resetb && rom_we_o !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                 rom_addr_o, rom_data_o, $time);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(rom_addr_o), 32'(e.addr));
        check("wr_data", 32'(rom_data_o), 32'(e.data));
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    tick();
    load_i      = 1'b1;
    bit_valid_i = 1'b0;
    exp_addr    = '0;
  endtask

  // Sends the top n bits of w MSB first, with gap idle cycles after each bit.
  task automatic send_bits(input logic [15:0] w, input int n, input int gap, input bit expect_write);
    for (int i = 15; i > 15 - n; i--) begin
      tick();
      bit_i       = w[i];
      bit_valid_i = 1'b1;
      if (i == 0 && expect_write) begin
        sb.push_back('{exp_addr, w, cyc + 1});
        exp_addr = exp_addr + 1'b1;
      end
      for (int g = 0; g < gap; g++) begin
        tick();
        bit_valid_i = 1'b0;
      end
    end
  endtask

  task automatic end_load();
    tick();
    bit_valid_i = 1'b0;
    load_i      = 1'b0;
    repeat (3) tick();
  endtask

  task automatic toggle_bits();
    for (int i = 0; i < 6; i++) begin
      tick();
      bit_valid_i = i[0];
      bit_i       = ~i[1];
    end
    tick();
    bit_valid_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(rom_we_o), 32'd0);
    check({tag, "_addr"}, 32'(rom_addr_o), 32'd0);
    check({tag, "_data"}, 32'(rom_data_o), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold_o), 32'd1);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetb = 1'b1;

    // Bits in IDLE are ignored.
    toggle_bits();
    check("idle_data", 32'(rom_data_o), 32'd0);
    check("idle_done", 32'(done_o), 32'd0);

    // Back-to-back bits, three words.
    start_load();
    send_bits(16'h1234, 16, 0, 1'b1);
    send_bits(16'hABCD, 16, 0, 1'b1);
    send_bits(16'hFFFF, 16, 0, 1'b1);
    end_load();
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_hold", 32'(cpu_hold_o), 32'd0);
    check("t1_err", 32'(err_o), 32'd0);
    check("t1_last_addr", 32'(rom_addr_o), 32'd2);

    // Bits in DONE are ignored.
    saved_data = rom_data_o;
    toggle_bits();
    check("done_data_kept", 32'(rom_data_o), 32'(saved_data));
    check("done_still", 32'(done_o), 32'd1);

    // Same words, one bit every third cycle.
    start_load();
    tick();
    check("t2_done_clr", 32'(done_o), 32'd0);
    check("t2_hold", 32'(cpu_hold_o), 32'd1);
    send_bits(16'h1234, 16, 2, 1'b1);
    send_bits(16'hABCD, 16, 2, 1'b1);
    send_bits(16'hFFFF, 16, 2, 1'b1);
    end_load();
    check("t2_done", 32'(done_o), 32'd1);
    check("t2_err", 32'(err_o), 32'd0);

    // Partial trailing word.
    start_load();
    send_bits(16'h00FF, 16, 0, 1'b1);
    send_bits(16'hA800, 5, 0, 1'b0);
    end_load();
    check("t3_done", 32'(done_o), 32'd1);
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_addr", 32'(rom_addr_o), 32'd0);

    // Address overflow with a 4-entry ROM.
    start_load();
    tick();
    check("t4_err_clr", 32'(err_o), 32'd0);
    send_bits(16'h0001, 16, 0, 1'b1);
    send_bits(16'h0002, 16, 0, 1'b1);
    send_bits(16'h0004, 16, 0, 1'b1);
    send_bits(16'h0008, 16, 0, 1'b1);
    send_bits(16'h8000, 16, 0, 1'b0);
    tick();
    tick();
    check("t4_err", 32'(err_o), 32'd1);
    check("t4_addr_sat", 32'(rom_addr_o), 32'd3);
    end_load();
    check("t4_done", 32'(done_o), 32'd1);
    check("t4_err_kept", 32'(err_o), 32'd1);

    // Reset in the middle of the second word.
    start_load();
    send_bits(16'h1111, 16, 0, 1'b1);
    send_bits(16'h2222, 9, 0, 1'b0);
    @(posedge clk);
    #3;
    resetb = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bit_valid_i = 1'b0;
    load_i      = 1'b0;
    tick();
    resetb = 1'b1;
    tick();
    start_load();
    send_bits(16'h5A5A, 16, 0, 1'b1);
    end_load();
    check("t5_done", 32'(done_o), 32'd1);
    check("t5_err", 32'(err_o), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
